serving_ram_seq: RTL and testbench

Wishbone-to-byte-RAM sequencer for the serving SoC: the initiator side of the byte-wide I/D SRAM port. It accepts one 32-bit Wishbone classic access at a time from the CPU/arbiter. Each access becomes four sequential byte writes, or four byte reads with one-cycle read latency. Read bytes are assembled little-endian into a 32-bit word, and the access completes with a single-cycle ack.

---
 rtl/serving_ram_seq.sv | 100 ++++++++++
 tb/tb_serving_ram_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serving_ram_seq.sv
`default_nettype none
// ============================================================================
// serving_ram_seq: Wishbone classic 32-bit access to byte-wide SRAM sequencer
// Revision: 1.0
// ============================================================================
module serving_ram_seq #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [AW-3:0] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic [AW-1:0] o_waddr,
  output logic [7:0]    o_wdata,
  output logic          o_wen,
  output logic [AW-1:0] o_raddr,
  input  logic [7:0]    i_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    READ   = 3'd2,
    RDWAIT = 3'd3,
    ACK    = 3'd4
  } state_t;

  state_t     r_state;
  logic [1:0] r_bcnt;
  logic       r_rvalid;

  // RAM side is a pure decode of the byte counter and the held Wishbone request
  assign o_waddr = {i_wb_adr, r_bcnt};
  assign o_raddr = {i_wb_adr, r_bcnt};
  assign o_wdata = i_wb_dat[{r_bcnt, 3'b000} +: 8];
  assign o_wen   = (r_state == WRITE) & i_wb_cyc & i_wb_sel[r_bcnt];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_bcnt   <= 2'd0;
      r_rvalid <= 1'b0;
      o_wb_ack <= 1'b0;
      o_wb_rdt <= 32'd0;
    end else begin
      r_rvalid <= (r_state == READ) & i_wb_cyc;
      o_wb_ack <= 1'b0;
      // Read data lags the address by one cycle, so capture runs one state behind
      if (r_rvalid)
        o_wb_rdt <= {i_rdata, o_wb_rdt[31:8]};
      case (r_state)
        IDLE: begin
          r_bcnt <= 2'd0;
          if (i_wb_cyc)
            r_state <= i_wb_we ? WRITE : READ;
        end
        WRITE: begin
          r_bcnt <= r_bcnt + 2'd1;
          if (!i_wb_cyc) begin
            r_state <= IDLE;
          end else if (r_bcnt == 2'd3) begin
            r_state  <= ACK;
            o_wb_ack <= 1'b1;
          end
        end
        READ: begin
          r_bcnt <= r_bcnt + 2'd1;
          if (!i_wb_cyc)
            r_state <= IDLE;
          else if (r_bcnt == 2'd3)
            r_state <= RDWAIT;
        end
        RDWAIT: begin
          if (!i_wb_cyc) begin
            r_state <= IDLE;
          end else begin
            r_state  <= ACK;
            o_wb_ack <= 1'b1;
          end
        end
        ACK: begin
          r_state <= IDLE;
          r_bcnt  <= 2'd0;
        end
        default: begin
          r_state <= IDLE;
          r_bcnt  <= 2'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serving_ram_seq.sv
`default_nettype none
// ============================================================================
// tb_serving_ram_seq: directed bench for serving_ram_seq with a byte RAM model
// Revision: 1.0
// ============================================================================
module tb_serving_ram_seq;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-3:0] wb_adr = '0;
  logic [31:0]   wb_dat = '0;
  logic [3:0]    wb_sel = '0;
  logic          wb_we  = 1'b0;
  logic          wb_cyc = 1'b0;
  logic [31:0]   wb_rdt;
  logic          wb_ack;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          wen;
  logic [AW-1:0] raddr;
  logic [7:0]    rdata;

  logic [7:0]    mem [DEPTH];
  logic          mem_init = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serving_ram_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_wb_adr (wb_adr),
    .i_wb_dat (wb_dat),
    .i_wb_sel (wb_sel),
    .i_wb_we  (wb_we),
    .i_wb_cyc (wb_cyc),
    .o_wb_rdt (wb_rdt),
    .o_wb_ack (wb_ack),
    .o_waddr  (waddr),
    .o_wdata  (wdata),
    .o_wen    (wen),
    .o_raddr  (raddr),
    .i_rdata  (rdata)
  );

  // Byte RAM with registered read; preloaded so that mem[i] = i
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i);
    end else if (wen) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a write in the current (IDLE) cycle N; returns at the start of N+6
  task automatic do_write(input logic [5:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [31:0] exp_rdt);
    wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = 1'b1; wb_cyc = 1'b1;
    @(negedge clk);
    chk("wr_ack_N", {31'd0, wb_ack}, 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wr_wen", {31'd0, wen}, {31'd0, sel[k]});
      chk("wr_waddr", {24'd0, waddr}, {24'd0, adr, 2'(k)});
      chk("wr_wdata", {24'd0, wdata}, {24'd0, dat[8*k +: 8]});
      chk("wr_ack_early", {31'd0, wb_ack}, 32'd0);
      tick();
    end
    @(negedge clk);
    chk("wr_ack", {31'd0, wb_ack}, 32'd1);
    chk("wr_wen_ack", {31'd0, wen}, 32'd0);
    chk("wr_rdt_kept", wb_rdt, exp_rdt);
    tick();
  endtask

  // Presents a read in cycle N; returns at the start of N+7
  task automatic do_read(input logic [5:0] adr, input logic [31:0] exp);
    wb_adr = adr; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1;
    @(negedge clk);
    chk("rd_ack_N", {31'd0, wb_ack}, 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rd_raddr", {24'd0, raddr}, {24'd0, adr, 2'(k)});
      chk("rd_wen", {31'd0, wen}, 32'd0);
      chk("rd_ack_early", {31'd0, wb_ack}, 32'd0);
      tick();
    end
    @(negedge clk);
    chk("rd_ack_rdwait", {31'd0, wb_ack}, 32'd0);
    tick();
    @(negedge clk);
    chk("rd_ack", {31'd0, wb_ack}, 32'd1);
    chk("rd_data", wb_rdt, exp);
    tick();
  endtask

  task automatic idle(input int n);
    wb_cyc = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle_ack", {31'd0, wb_ack}, 32'd0);
      chk("idle_wen", {31'd0, wen}, 32'd0);
      tick();
    end
  endtask

  initial begin
    tick(); tick(); tick();
    mem_init = 1'b0;
    @(negedge clk);
    chk("rst_ack", {31'd0, wb_ack}, 32'd0);
    chk("rst_rdt", wb_rdt, 32'd0);
    chk("rst_wen", {31'd0, wen}, 32'd0);
    rst = 1'b0;
    tick();
    idle(2);

    // Full write then read back
    do_write(6'h05, 32'hDEADBEEF, 4'hF, 32'h0);
    idle(1);
    do_read(6'h05, 32'hDEADBEEF);
    idle(1);

    // Partial write: bytes 0 and 2 only
    do_write(6'h05, 32'h11223344, 4'b0101, 32'hDEADBEEF);
    idle(1);
    do_read(6'h05, 32'hDE22BE44);
    idle(1);

    // Empty byte mask: memory at word 0 keeps its preload
    do_write(6'h00, 32'hFFFFFFFF, 4'b0000, 32'hDE22BE44);
    idle(1);
    do_read(6'h00, 32'h03020100);
    idle(1);

    // Back-to-back: write presented the cycle after the read ack
    do_read(6'h05, 32'hDE22BE44);
    do_write(6'h01, 32'hCAFEF00D, 4'hF, 32'hDE22BE44);
    idle(1);
    do_read(6'h01, 32'hCAFEF00D);
    idle(1);

    // Reset during cycle N+2 of a write: bytes 0 and 1 land, rest do not
    wb_adr = 6'h02; wb_dat = 32'h55667788; wb_sel = 4'hF; wb_we = 1'b1; wb_cyc = 1'b1;
    tick();                       // N+1
    tick();                       // N+2
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_wen_N2", {31'd0, wen}, 32'd1);
    tick();                       // N+3
    rst = 1'b0;
    wb_cyc = 1'b0;
    @(negedge clk);
    chk("rst_mid_wen", {31'd0, wen}, 32'd0);
    chk("rst_mid_ack", {31'd0, wb_ack}, 32'd0);
    chk("rst_mid_rdt", wb_rdt, 32'd0);
    tick();
    idle(6);
    do_read(6'h02, 32'h0B0A7788);
    idle(1);

    // Abort a read at N+2; the design must be IDLE and accept a write at N+3
    wb_adr = 6'h05; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1;
    tick();                       // N+1
    tick();                       // N+2
    wb_cyc = 1'b0;
    @(negedge clk);
    chk("abort_ack", {31'd0, wb_ack}, 32'd0);
    tick();                       // N+3
    do_write(6'h03, 32'hA5A5A5A5, 4'hF, wb_rdt);
    idle(1);
    do_read(6'h03, 32'hA5A5A5A5);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
